bpsk_corr_demod: RTL and testbench

Coherent BPSK symbol demodulator, the receive-side counterpart of the carrier generator.
- Drives the phase address of an external cosine lookup and multiplies each incoming baseband/IF sample by the returned carrier value.
- Integrates the products over one symbol period (integrate-and-dump), then makes a hard sign decision.
- Presents each decided bit with a valid/ready handshake to the downstream framer.

---
 rtl/bpsk_corr_demod.sv | 171 +++++++++++++++++
 tb/tb_bpsk_corr_demod.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_corr_demod.sv
// bpsk_corr_demod: coherent BPSK integrate-and-dump demodulator.
// Drives the phase address of an external cosine LUT and multiplies each accepted
// sample by the returned carrier value. It integrates the products over one symbol,
// then hard-decides the sign. The decided bit is handed downstream with valid/ready.
// Optional feature: define BPSK_DIFF_DECODE_EN for differential decoding of bit_out.
// With that macro, bit_out = raw XOR previous raw, which removes the 180-degree ambiguity.
module bpsk_corr_demod #(
    parameter int SAMPLES_PER_SYMBOL = 16,
    parameter int PHASE_BITS         = 9,
    parameter int PHASE_STEP         = 32,
    parameter int LUT_BITS           = 12,
    parameter int SAMPLE_BITS        = 12,
    parameter int ACC_BITS           = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [PHASE_BITS-1:0]  phase_offset,
    input  logic                   sample_valid,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    output logic [PHASE_BITS-1:0]  lut_addr,
    input  logic [LUT_BITS-1:0]    lut_data,
    output logic                   bit_valid,
    input  logic                   bit_ready,
    output logic                   bit_out,
    output logic [ACC_BITS-1:0]    metric_out,
    output logic                   overrun,
    output logic                   busy
);

    localparam int PROD_BITS = SAMPLE_BITS + LUT_BITS;
    localparam int CNT_BITS  = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(SAMPLES_PER_SYMBOL - 1);

    typedef enum logic {
        IDLE      = 1'b0,
        INTEGRATE = 1'b1
    } state_t;

    state_t                     state_reg, state_next;
    logic signed [ACC_BITS-1:0] acc_reg, acc_next;
    logic [CNT_BITS-1:0]        count_reg, count_next;
    logic [PHASE_BITS-1:0]      phase_reg, phase_next;
    logic                       valid_reg, valid_next;
    logic                       bit_reg, bit_next;
    logic [ACC_BITS-1:0]        metric_reg, metric_next;
    logic                       overrun_reg, overrun_next;

    logic signed [PROD_BITS-1:0] product;
    logic signed [ACC_BITS-1:0]  product_ext;
    logic signed [ACC_BITS-1:0]  sum;
    logic                        accept;
    logic                        sym_end;
    logic                        raw_decision;
    logic                        decided_bit;

    // Full-precision signed product, sign-extended into the accumulator width
    assign product     = PROD_BITS'($signed(sample_in)) * PROD_BITS'($signed(lut_data));
    assign product_ext = ACC_BITS'(product);
    assign sum         = acc_reg + product_ext;

    assign accept       = (state_reg == INTEGRATE) && sample_valid;
    assign sym_end      = accept && (count_reg == LAST_COUNT);
    // A zero correlation sum decides 1
    assign raw_decision = ~sum[ACC_BITS-1];

`ifdef BPSK_DIFF_DECODE_EN
    logic prev_raw_reg, prev_raw_next;
    assign decided_bit = raw_decision ^ prev_raw_reg;
`else
    assign decided_bit = raw_decision;
`endif

    // Next-state, integrator and output-handshake logic
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        count_next   = count_reg;
        phase_next   = phase_reg;
        valid_next   = valid_reg;
        bit_next     = bit_reg;
        metric_next  = metric_reg;
        overrun_next = overrun_reg;
`ifdef BPSK_DIFF_DECODE_EN
        prev_raw_next = prev_raw_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = INTEGRATE;
                    phase_next = phase_offset;
                    acc_next   = '0;
                    count_next = '0;
                end
            end
            INTEGRATE: begin
                if (sym_end) begin
                    // Phase realigns to the offset at every symbol boundary
                    acc_next   = '0;
                    count_next = '0;
                    phase_next = phase_offset;
                    if (!en) begin
                        state_next = IDLE;
                    end
                end else if (!en) begin
                    // Abort: the partial symbol is thrown away
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
                end else if (accept) begin
                    acc_next   = sum;
                    phase_next = phase_reg + PHASE_BITS'(PHASE_STEP);
                    count_next = count_reg + CNT_BITS'(1);
                end
            end
        endcase

        if (sym_end) begin
            // A finished symbol always loads; an unaccepted previous one is lost
            valid_next  = 1'b1;
            metric_next = sum;
            bit_next    = decided_bit;
            if (valid_reg && !bit_ready) begin
                overrun_next = 1'b1;
            end
`ifdef BPSK_DIFF_DECODE_EN
            prev_raw_next = raw_decision;
`endif
        end else if (valid_reg && bit_ready) begin
            valid_next = 1'b0;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            count_reg   <= '0;
            phase_reg   <= '0;
            valid_reg   <= 1'b0;
            bit_reg     <= 1'b0;
            metric_reg  <= '0;
            overrun_reg <= 1'b0;
`ifdef BPSK_DIFF_DECODE_EN
            prev_raw_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            phase_reg   <= phase_next;
            valid_reg   <= valid_next;
            bit_reg     <= bit_next;
            metric_reg  <= metric_next;
            overrun_reg <= overrun_next;
`ifdef BPSK_DIFF_DECODE_EN
            prev_raw_reg <= prev_raw_next;
`endif
        end
    end

    assign lut_addr   = phase_reg;
    assign bit_valid  = valid_reg;
    assign bit_out    = bit_reg;
    assign metric_out = metric_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg == INTEGRATE);

endmodule

// File: tb/tb_bpsk_corr_demod.sv
// Directed self-checking bench for bpsk_corr_demod with a 16-point cosine LUT model.
module tb_bpsk_corr_demod;

    localparam int SPS = 16;
    localparam int PB  = 9;
    localparam int LB  = 12;
    localparam int SB  = 12;
    localparam int AB  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [PB-1:0] phase_offset;
    logic          sample_valid;
    logic [SB-1:0] sample_in;
    logic [PB-1:0] lut_addr;
    logic [LB-1:0] lut_data;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_out;
    logic [AB-1:0] metric_out;
    logic          overrun;
    logic          busy;

    int errs   = 0;
    int checks = 0;
    longint sumsq;
`ifdef BPSK_DIFF_DECODE_EN
    bit prev_raw = 1'b0;
`endif

    // Cosine samples at the 16 phases 0,32,...,480 (addr[8:5])
    int cos_tbl [16] = '{2047, 1891, 1447, 783, 0, -783, -1447, -1891,
                         -2047, -1891, -1447, -783, 0, 783, 1447, 1891};

    always #5 clk = ~clk;

    assign lut_data = LB'(cos_tbl[lut_addr[8:5]]);

    bpsk_corr_demod dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .phase_offset (phase_offset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .bit_out      (bit_out),
        .metric_out   (metric_out),
        .overrun      (overrun),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: sample = +carrier, 1: -carrier, 2: zero
    function automatic longint exp_metric(input int mode);
        case (mode)
            0:       exp_metric = sumsq;
            1:       exp_metric = -sumsq;
            default: exp_metric = 0;
        endcase
    endfunction

    function automatic bit model_bit(input bit raw);
`ifdef BPSK_DIFF_DECODE_EN
        model_bit = raw ^ prev_raw;
        prev_raw  = raw;
`else
        model_bit = raw;
`endif
    endfunction

    // Feed n samples starting at a negedge; checks the carrier phase of each sample
    task automatic send_samples(input int mode, input int gap, input logic [PB-1:0] base,
                                input int n);
        logic [PB-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + PB'(32 * i);
            check("lut_addr", lut_addr, a);
            sample_valid = 1'b1;
            case (mode)
                0:       sample_in = lut_data;
                1:       sample_in = -lut_data;
                default: sample_in = '0;
            endcase
            @(negedge clk);
            sample_valid = 1'b0;
            if (i != n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_symbol(input string tag, input int mode);
        bit e;
        e = model_bit(exp_metric(mode) >= 0);
        check({tag, "_valid"}, bit_valid, 1);
        check({tag, "_bit"}, bit_out, e);
        check({tag, "_metric"}, $signed(metric_out), exp_metric(mode));
        $display("symbol %s: bit=%0d metric=%0d overrun=%0d", tag, bit_out,
                 $signed(metric_out), overrun);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp6 [4];
        sumsq = 0;
        foreach (cos_tbl[i]) sumsq += longint'(cos_tbl[i]) * longint'(cos_tbl[i]);
`ifdef BPSK_DIFF_DECODE_EN
        exp6 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp6 = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; sample_in = '0;
        bit_ready = 1'b0; phase_offset = '0;
        repeat (2) @(negedge clk);
        check("rst_addr", lut_addr, 0);
        check("rst_valid", bit_valid, 0);
        check("rst_bit", bit_out, 0);
        check("rst_metric", metric_out, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Samples while idle are ignored
        sample_valid = 1'b1; sample_in = 12'd1000;
        repeat (3) @(negedge clk);
        sample_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_addr", lut_addr, 0);

        // 1: in-phase symbol
        en = 1'b1;
        @(negedge clk);
        check("t1_busy", busy, 1);
        send_samples(0, 0, 0, SPS);
        check_symbol("t1", 0);
        check("t1_addr_realign", lut_addr, 0);
        bit_ready = 1'b1;
        @(negedge clk);
        check("t1_accept", bit_valid, 0);
        bit_ready = 1'b0;

        // 2: anti-phase symbol
        send_samples(1, 0, 0, SPS);
        check_symbol("t2", 1);
        check("t2_addr_realign", lut_addr, 0);
        bit_ready = 1'b1;
        @(negedge clk);
        check("t2_accept", bit_valid, 0);

        // 3: back-to-back symbols 1,0,1 with sample gaps
        for (int s = 0; s < 3; s++) begin
            send_samples((s == 1) ? 1 : 0, 3, 0, SPS);
            check_symbol("t3", (s == 1) ? 1 : 0);
            @(negedge clk);
            check("t3_drop", bit_valid, 0);
        end
        check("t3_overrun", overrun, 0);

        // Zero correlation decides 1
        send_samples(2, 1, 0, SPS);
        check_symbol("zero", 2);
        @(negedge clk);
        check("zero_drop", bit_valid, 0);

        // 4: overrun
        bit_ready = 1'b0;
        send_samples(0, 0, 0, SPS);
        check_symbol("t4a", 0);
        check("t4a_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        check("t4_hold_valid", bit_valid, 1);
        check("t4_hold_metric", $signed(metric_out), sumsq);
        send_samples(1, 0, 0, SPS);
        check_symbol("t4b", 1);
        check("t4b_overrun", overrun, 1);
        bit_ready = 1'b1;
        @(negedge clk);
        check("t4_accept", bit_valid, 0);
        check("t4_sticky", overrun, 1);

        // 5: abort after 7 samples, restart at phase 128
        send_samples(0, 0, 0, 7);
        en = 1'b0;
        @(negedge clk);
        check("t5_abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t5_no_bit", bit_valid, 0);
        phase_offset = 9'd128; en = 1'b1;
        @(negedge clk);
        check("t5_busy", busy, 1);
        check("t5_start_addr", lut_addr, 128);
        bit_ready = 1'b0;
        send_samples(0, 0, 9'd128, SPS);
        check_symbol("t5", 0);
        send_samples(0, 0, 9'd128, 5);
        #1 rst_n = 1'b0;
`ifdef BPSK_DIFF_DECODE_EN
        prev_raw = 1'b0;
`endif
        #1;
        check("arst_addr", lut_addr, 0);
        check("arst_valid", bit_valid, 0);
        check("arst_bit", bit_out, 0);
        check("arst_metric", metric_out, 0);
        check("arst_overrun", overrun, 0);
        check("arst_busy", busy, 0);
        phase_offset = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // 6: raw symbols 1,1,0,0
        bit_ready = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            send_samples((s < 2) ? 0 : 1, 0, 0, SPS);
            check("t6_valid", bit_valid, 1);
            check("t6_bit", bit_out, exp6[s]);
            $display("symbol t6[%0d]: bit=%0d metric=%0d", s, bit_out, $signed(metric_out));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
